// File: rtl/dds_sweep_ctrl.sv
// dds_sweep_ctrl -- frequency-sweep sequencer for the phase-accumulator DDS.
//
// This block is the only writer of the DDS tuning word. A start strobe
// captures the whole configuration into shadow registers. The block then
// loads the start word, steps it by +/- cfg_ftw_step cfg_steps times, and
// holds each point for cfg_dwell+1 cycles.
//
// Optional feature macro: DDS_SWEEP_LOOP_EN
//   When defined, the block adds the input cfg_loop. With cfg_loop=1 the
//   sweep restarts from the start word after the last point instead of
//   finishing. It keeps restarting until abort.
//
// Ports
//   clock, reset      rising-edge clock; asynchronous active-high reset
//   start             begin a sweep (sampled only while idle)
//   abort             end the sweep at the next edge, with no done pulse
//   cfg_ftw_start     first tuning word
//   cfg_ftw_step      step magnitude
//   cfg_down          0 = add the step, 1 = subtract the step
//   cfg_steps         number of increments (a sweep has cfg_steps+1 points)
//   cfg_dwell         extra hold cycles for each point
//   cfg_loop          (DDS_SWEEP_LOOP_EN only) repeat the sweep until abort
//   ftw               tuning word driven to the DDS
//   ftw_load          one-cycle strobe, high when ftw has just changed
//   phase_clr         one-cycle strobe that clears the DDS phase accumulator
//   busy              high while a sweep is in progress
//   done              one-cycle pulse when a sweep completes normally
//   step_idx          index of the point currently on ftw
module dds_sweep_ctrl #(
  parameter int FTW_W   = 32,
  parameter int CNT_W   = 16,
  parameter int DWELL_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [FTW_W-1:0]   cfg_ftw_start,
  input  logic [FTW_W-1:0]   cfg_ftw_step,
  input  logic               cfg_down,
  input  logic [CNT_W-1:0]   cfg_steps,
  input  logic [DWELL_W-1:0] cfg_dwell,
`ifdef DDS_SWEEP_LOOP_EN
  input  logic               cfg_loop,
`endif
  output logic [FTW_W-1:0]   ftw,
  output logic               ftw_load,
  output logic               phase_clr,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   step_idx
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DWELL = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Configuration captured at start. A running sweep never looks at the
  // live cfg_* inputs again.
  typedef struct packed {
    logic [FTW_W-1:0]   ftw_start;
    logic [FTW_W-1:0]   ftw_step;
    logic               down;
    logic [CNT_W-1:0]   steps;
    logic [DWELL_W-1:0] dwell;
    logic               loop;
  } sweep_cfg_t;

  logic [1:0]         state;
  sweep_cfg_t         cfg_sh;
  sweep_cfg_t         cfg_in;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [FTW_W-1:0]   ftw_next;
  logic               last_pt;
  logic               dwell_end;

  always_comb begin
    cfg_in.ftw_start = cfg_ftw_start;
    cfg_in.ftw_step  = cfg_ftw_step;
    cfg_in.down      = cfg_down;
    cfg_in.steps     = cfg_steps;
    cfg_in.dwell     = cfg_dwell;
`ifdef DDS_SWEEP_LOOP_EN
    cfg_in.loop      = cfg_loop;
`else
    cfg_in.loop      = 1'b0;
`endif
  end

  // Modular add or subtract. A carry or borrow out of the top bit is
  // dropped on purpose, so the word wraps around the DDS frequency circle.
  assign ftw_next  = cfg_sh.down ? (ftw - cfg_sh.ftw_step) : (ftw + cfg_sh.ftw_step);
  assign dwell_end = (dwell_cnt == '0);
  assign last_pt   = (step_idx == cfg_sh.steps);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cfg_sh    <= '0;
      dwell_cnt <= '0;
      ftw       <= '0;
      ftw_load  <= 1'b0;
      phase_clr <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      step_idx  <= '0;
    end else begin
      // The strobes default low. Only the edges listed below raise them.
      ftw_load  <= 1'b0;
      phase_clr <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cfg_sh <= cfg_in;
            busy   <= 1'b1;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            ftw       <= cfg_sh.ftw_start;
            ftw_load  <= 1'b1;
            phase_clr <= 1'b1;
            step_idx  <= '0;
            dwell_cnt <= cfg_sh.dwell;
            state     <= S_DWELL;
          end
        end
        S_DWELL: begin
          // abort is tested first, so it beats a step that falls on the same edge.
          if (abort) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (!dwell_end) begin
            dwell_cnt <= dwell_cnt - DWELL_W'(1);
          end else if (!last_pt) begin
            ftw       <= ftw_next;
            step_idx  <= step_idx + CNT_W'(1);
            ftw_load  <= 1'b1;
            dwell_cnt <= cfg_sh.dwell;
          end else if (cfg_sh.loop) begin
            // Loop mode: reload the start word. busy stays high.
            state <= S_LOAD;
          end else begin
            // busy falls on the same edge that raises done.
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          // Sweep already finished. An abort here would also go to idle.
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
module tb_dds_sweep_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [31:0] cfg_ftw_start;
  logic [31:0] cfg_ftw_step;
  logic        cfg_down;
  logic [15:0] cfg_steps;
  logic [15:0] cfg_dwell;
`ifdef DDS_SWEEP_LOOP_EN
  logic        cfg_loop;
`endif
  logic [31:0] ftw;
  logic        ftw_load;
  logic        phase_clr;
  logic        busy;
  logic        done;
  logic [15:0] step_idx;

  int checks = 0;
  int errors = 0;

  // What ftw/step_idx should be holding now (the model's memory between sweeps).
  logic [31:0] last_ftw = '0;
  logic [15:0] last_idx = '0;

  always #5 clock = ~clock;

  dds_sweep_ctrl dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .cfg_ftw_start(cfg_ftw_start), .cfg_ftw_step(cfg_ftw_step),
    .cfg_down(cfg_down), .cfg_steps(cfg_steps), .cfg_dwell(cfg_dwell),
`ifdef DDS_SWEEP_LOOP_EN
    .cfg_loop(cfg_loop),
`endif
    .ftw(ftw), .ftw_load(ftw_load), .phase_clr(phase_clr),
    .busy(busy), .done(done), .step_idx(step_idx)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Run one sweep and compare every cycle against arithmetic expectations.
  // Times are counted in edges after the start-sampling edge (t=0).
  // abort_at >= 0 raises abort for edge t=abort_at+1.
  // noise: random start pulses while busy, and random cfg_* changes after start.
  task automatic run_sweep(input logic [31:0] s, input logic [31:0] st,
                           input logic dn, input int n, input int d,
                           input int abort_at, input bit noise, input string tag);
    int period, tdone, tend, tt, p, limit;
    logic [31:0] ef;
    logic [15:0] ei;
    logic el, ep, eb, ed;
    period = d + 1;
    tdone  = (n + 1) * period + 1;
    tend   = (abort_at >= 0) ? abort_at + 3 : tdone + 2;
    limit  = (abort_at >= 0) ? abort_at - 1 : tdone;
    cfg_ftw_start = s; cfg_ftw_step = st; cfg_down = dn;
    cfg_steps = 16'(n); cfg_dwell = 16'(d);
`ifdef DDS_SWEEP_LOOP_EN
    cfg_loop = 1'b0;
`endif
    start = 1'b1; abort = 1'b0;
    tick();
    ef = last_ftw; ei = last_idx;
    for (int t = 0; t <= tend; t++) begin
      if (t > 0) tick();
      tt = (abort_at >= 0 && t > abort_at) ? abort_at : t;
      if (tt == 0) begin
        ef = last_ftw; ei = last_idx;
      end else begin
        p = (tt - 1) / period;
        if (p > n) p = n;
        ef = dn ? (s - st * 32'(p)) : (s + st * 32'(p));
        ei = 16'(p);
      end
      el = (t >= 1) && (t < tdone) && (abort_at < 0 || t <= abort_at) && ((t - 1) % period == 0);
      ep = (t == 1) && (abort_at < 0 || abort_at >= 1);
      eb = (abort_at >= 0) ? (t <= abort_at) : (t < tdone);
      ed = (abort_at < 0) && (t == tdone);
      checks++;
      if ({ftw, step_idx, ftw_load, phase_clr, busy, done} !== {ef, ei, el, ep, eb, ed}) begin
        errors++;
        $display("FAIL %s t=%0d: got ftw=%h idx=%0d ld=%b pc=%b busy=%b done=%b, want ftw=%h idx=%0d ld=%b pc=%b busy=%b done=%b",
                 tag, t, ftw, step_idx, ftw_load, phase_clr, busy, done, ef, ei, el, ep, eb, ed);
      end
      start = (noise && t <= limit) ? 1'($urandom_range(0, 1)) : 1'b0;
      abort = (abort_at >= 0 && t == abort_at);
      if (noise) begin
        cfg_ftw_start = $urandom; cfg_ftw_step = $urandom; cfg_down = 1'($urandom);
        cfg_steps = 16'($urandom); cfg_dwell = 16'($urandom_range(0, 3));
      end
    end
    last_ftw = ef; last_idx = ei;
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_ftw_start = '0; cfg_ftw_step = '0; cfg_down = 1'b0; cfg_steps = '0; cfg_dwell = '0;
`ifdef DDS_SWEEP_LOOP_EN
    cfg_loop = 1'b0;
`endif
    tick(); tick();
    checks++;
    if ({ftw, step_idx, ftw_load, phase_clr, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_state: got ftw=%h idx=%0d ld=%b pc=%b busy=%b done=%b, want all 0",
               ftw, step_idx, ftw_load, phase_clr, busy, done);
    end
    reset = 1'b0;
    tick(); tick();
    checks++;
    if ({busy, ftw_load, ftw} !== '0) begin
      errors++;
      $display("FAIL idle_no_start: got busy=%b ld=%b ftw=%h, want 0", busy, ftw_load, ftw);
    end
  endtask

  task automatic test_reset_mid_sweep();
    cfg_ftw_start = 32'h0ABC_0000; cfg_ftw_step = 32'h1; cfg_down = 1'b0;
    cfg_steps = 16'd6; cfg_dwell = 16'd1;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick(); tick();
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({ftw, step_idx, ftw_load, phase_clr, busy, done} !== '0) begin
      errors++;
      $display("FAIL async_reset: got ftw=%h idx=%0d ld=%b pc=%b busy=%b done=%b, want all 0",
               ftw, step_idx, ftw_load, phase_clr, busy, done);
    end
    tick(); tick();
    reset = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({ftw, busy, ftw_load} !== '0) begin
      errors++;
      $display("FAIL no_resume_after_reset: got ftw=%h busy=%b ld=%b, want 0", ftw, busy, ftw_load);
    end
    last_ftw = '0; last_idx = '0;
    run_sweep(32'h100, 32'h10, 1'b0, 3, 2, -1, 1'b0, "basic_up");
  endtask

  task automatic test_wrap();
    run_sweep(32'hFFFF_FFF0, 32'h20, 1'b0, 1, 0, -1, 1'b0, "wrap");
  endtask

  task automatic test_down();
    run_sweep(32'h1000, 32'h100, 1'b1, 2, 1, -1, 1'b0, "down");
  endtask

  task automatic test_single_point_busy_start();
    run_sweep(32'h00C0_FFEE, 32'h55, 1'b0, 0, 5, -1, 1'b1, "single_pt");
  endtask

  task automatic test_abort();
    // second point is loaded at t=4 (dwell 2), abort lands at edge t=6
    run_sweep(32'h2000, 32'h40, 1'b0, 4, 2, 5, 1'b0, "abort_2nd");
    run_sweep(32'h3000, 32'h8, 1'b1, 3, 1, -1, 1'b0, "after_abort");
    run_sweep(32'h7777, 32'h1, 1'b0, 2, 0, 0, 1'b0, "abort_in_load");
  endtask

  task automatic test_random();
    int n, d, ab;
    for (int i = 0; i < 25; i++) begin
      n = $urandom_range(0, 5);
      d = $urandom_range(0, 4);
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, (n + 1) * (d + 1))) : -1;
      run_sweep($urandom, $urandom, 1'($urandom), n, d, ab, 1'b1, "random");
    end
  endtask

`ifdef DDS_SWEEP_LOOP_EN
  task automatic test_loop();
    logic [31:0] s, st, ef;
    logic [15:0] ei;
    logic el, ep;
    s = 32'h5000; st = 32'h30;
    cfg_ftw_start = s; cfg_ftw_step = st; cfg_down = 1'b0;
    cfg_steps = 16'd1; cfg_dwell = 16'd0; cfg_loop = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      // one loop lap = load start, step, reload gap: three cycles
      ef = ((t - 1) % 3 == 0) ? s : s + st;
      ei = ((t - 1) % 3 == 0) ? 16'd0 : 16'd1;
      el = ((t - 1) % 3 != 2);
      ep = ((t - 1) % 3 == 0);
      checks++;
      if ({ftw, step_idx, ftw_load, phase_clr, busy, done} !== {ef, ei, el, ep, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL loop t=%0d: got ftw=%h idx=%0d ld=%b pc=%b busy=%b done=%b, want ftw=%h idx=%0d ld=%b pc=%b busy=1 done=0",
                 t, ftw, step_idx, ftw_load, phase_clr, busy, done, ef, ei, el, ep);
      end
    end
    abort = 1'b1; tick(); abort = 1'b0;
    checks++;
    if ({ftw, step_idx, busy, done} !== {s + st, 16'd1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL loop_abort: got ftw=%h idx=%0d busy=%b done=%b, want ftw=%h idx=1 busy=0 done=0",
               ftw, step_idx, busy, done, s + st);
    end
    cfg_loop = 1'b0;
    last_ftw = s + st; last_idx = 16'd1;
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_sweep();
    test_wrap();
    test_down();
    test_single_point_busy_start();
    test_abort();
`ifdef DDS_SWEEP_LOOP_EN
    test_loop();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
